// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//    Sends the local player's state (id, x, y, collision) to the UART TX FIFO
//    as a 6-byte nibble packet. Each byte carries an opcode in the low nibble
//    and a payload nibble in the high nibble, which is the format the receive
//    side decoder expects. A packet is started on a frame tick when this is
//    the first packet, when the state has changed since the last packet, or
//    when the refresh interval has elapsed. Writes stall while the FIFO is
//    full, so bytes are never dropped or duplicated.
//
// Parameters:
//    REFRESH_FRAMES  frame ticks after which a packet is forced even with no
//                    change (must be >= 1)
//
// Ports:
//    clk              in   system clock
//    rst              in   synchronous, active-high reset
//    frame_tick       in   one-cycle pulse per video frame
//    tx_enable        in   link active; low = no new packets are started
//    local_id  [1:0]  in   player id carried in the SELECT byte
//    local_x   [7:0]  in   current local x position
//    local_y   [7:0]  in   current local y position
//    local_collision  in   current local collision flag
//    tx_full          in   UART TX FIFO full
//    w_data    [7:0]  out  byte to the FIFO (valid while sending)
//    wr_uart          out  FIFO write strobe, one byte per high cycle
//    busy             out  packet in progress
//    pkt_done         out  one-cycle pulse after the last byte is written
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int REFRESH_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       tx_enable,
   input  logic [1:0] local_id,
   input  logic [7:0] local_x,
   input  logic [7:0] local_y,
   input  logic       local_collision,
   input  logic       tx_full,
   output logic [7:0] w_data,
   output logic       wr_uart,
   output logic       busy,
   output logic       pkt_done
);

   // The refresh counter only ever needs to reach REFRESH_FRAMES-1.
   localparam int CNT_W = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_FRAMES - 1);
   localparam logic [2:0] LAST_IDX = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;

   logic [2:0]       r_idx;

   // Snapshot of the packet in flight; the bytes are built only from these.
   logic [1:0]       r_snapId;
   logic [7:0]       r_snapX;
   logic [7:0]       r_snapY;
   logic             r_snapCol;

   // Values carried by the most recently started packet, for change detection.
   logic [1:0]       r_lastId;
   logic [7:0]       r_lastX;
   logic [7:0]       r_lastY;
   logic             r_lastCol;

   logic             r_pending;
   logic             r_firstPkt;
   logic [CNT_W-1:0] r_refreshCnt;

   logic             w_changed;
   logic             w_startCond;
   logic             w_launch;
   logic             w_idleTick;
   logic             w_doneEval;
   logic [7:0]       w_sendByte;

   // A packet is due if none has been sent yet, the state differs from what
   // was last sent, or the refresh interval has run out.
   assign w_changed   = ({local_id, local_x, local_y, local_collision} !=
                         {r_lastId, r_lastX, r_lastY, r_lastCol});
   assign w_startCond = r_firstPkt || w_changed || (r_refreshCnt >= CNT_MAX);

   // In DONE a tick that arrived while busy (or arrives right now) is
   // evaluated as though it had just come in while idle.
   assign w_doneEval  = (r_pending || frame_tick) && tx_enable;

   // Byte encoder: low nibble is the opcode (equal to the byte index),
   // high nibble is the payload. y is sent high nibble first.
   always_comb begin
      w_sendByte = 8'h00;
      case (r_idx)
         3'd0:    w_sendByte = {2'b00, r_snapId, 4'h0};
         3'd1:    w_sendByte = {r_snapX[3:0], 4'h1};
         3'd2:    w_sendByte = {r_snapX[7:4], 4'h2};
         3'd3:    w_sendByte = {r_snapY[7:4], 4'h3};
         3'd4:    w_sendByte = {r_snapY[3:0], 4'h4};
         3'd5:    w_sendByte = {3'b000, r_snapCol, 4'h5};
         default: w_sendByte = 8'h00;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and output decode. w_launch starts a new packet,
   // w_idleTick marks a send evaluation that did not start one (the refresh
   // counter advances on those).
   always_comb begin
      w_stateNext = r_state;
      w_launch    = 1'b0;
      w_idleTick  = 1'b0;
      wr_uart     = 1'b0;
      w_data      = 8'h00;
      busy        = 1'b0;
      pkt_done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (frame_tick && tx_enable) begin
               if (w_startCond) begin
                  w_launch    = 1'b1;
                  w_stateNext = SEND;
               end else begin
                  w_idleTick  = 1'b1;
               end
            end
         end
         SEND: begin
            busy    = 1'b1;
            wr_uart = !tx_full;
            w_data  = w_sendByte;
            if (!tx_full && (r_idx == LAST_IDX)) begin
               w_stateNext = DONE;
            end
         end
         DONE: begin
            busy     = 1'b1;
            pkt_done = 1'b1;
            if (w_doneEval && w_startCond) begin
               w_launch    = 1'b1;
               w_stateNext = SEND;
            end else begin
               w_idleTick  = w_doneEval;
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Packet bookkeeping: snapshot/last-sent capture, byte index, refresh
   // counter and first-packet flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= 3'd0;
         r_snapId     <= 2'd0;
         r_snapX      <= 8'd0;
         r_snapY      <= 8'd0;
         r_snapCol    <= 1'b0;
         r_lastId     <= 2'd0;
         r_lastX      <= 8'd0;
         r_lastY      <= 8'd0;
         r_lastCol    <= 1'b0;
         r_refreshCnt <= '0;
         r_firstPkt   <= 1'b1;
      end else begin
         if (w_launch) begin
            r_idx        <= 3'd0;
            r_snapId     <= local_id;
            r_snapX      <= local_x;
            r_snapY      <= local_y;
            r_snapCol    <= local_collision;
            r_lastId     <= local_id;
            r_lastX      <= local_x;
            r_lastY      <= local_y;
            r_lastCol    <= local_collision;
            r_refreshCnt <= '0;
            r_firstPkt   <= 1'b0;
         end else begin
            if (wr_uart) begin
               r_idx <= r_idx + 3'd1;
            end
            if (w_idleTick && (r_refreshCnt != CNT_MAX)) begin
               r_refreshCnt <= r_refreshCnt + 1'b1;
            end
         end
      end
   end

   // Ticks during a packet collapse into a single pending request, which is
   // consumed in DONE. Dropping tx_enable discards any pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= 1'b0;
      end else if (r_state == SEND) begin
         if (!tx_enable) begin
            r_pending <= 1'b0;
         end else if (frame_tick) begin
            r_pending <= 1'b1;
         end
      end else begin
         r_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Purpose:
//    Self-checking bench for uart_tx_scheduler. A packet-level reference
//    model (a queue of bytes still owed to the FIFO plus the send rules)
//    predicts the DUT outputs every cycle. Directed steps cover the main
//    scenarios, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

   localparam int RF = 4;

   logic       clk;
   logic       rst;
   logic       frame_tick;
   logic       tx_enable;
   logic [1:0] local_id;
   logic [7:0] local_x;
   logic [7:0] local_y;
   logic       local_collision;
   logic       tx_full;
   logic [7:0] w_data;
   logic       wr_uart;
   logic       busy;
   logic       pkt_done;

   int compared;
   int mismatched;

   // Bytes observed on the FIFO write port, cleared by each directed step.
   logic [7:0] wrLog[$];

   // Reference model state.
   logic [7:0] mQ[$];
   bit         mDone;
   bit         mPend;
   bit         mFirst;
   int         mCnt;
   logic [1:0] mId;
   logic [7:0] mX;
   logic [7:0] mY;
   logic       mCol;

   uart_tx_scheduler #(
      .REFRESH_FRAMES(RF)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .tx_enable      (tx_enable),
      .local_id       (local_id),
      .local_x        (local_x),
      .local_y        (local_y),
      .local_collision(local_collision),
      .tx_full        (tx_full),
      .w_data         (w_data),
      .wr_uart        (wr_uart),
      .busy           (busy),
      .pkt_done       (pkt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Send rule: first packet, any field changed, or refresh interval reached.
   function automatic bit startOk();
      return mFirst ||
             ({local_id, local_x, local_y, local_collision} != {mId, mX, mY, mCol}) ||
             (mCnt >= RF - 1);
   endfunction

   task automatic launch();
      mQ.delete();
      mQ.push_back({2'b00, local_id, 4'h0});
      mQ.push_back({local_x[3:0], 4'h1});
      mQ.push_back({local_x[7:4], 4'h2});
      mQ.push_back({local_y[7:4], 4'h3});
      mQ.push_back({local_y[3:0], 4'h4});
      mQ.push_back({3'b000, local_collision, 4'h5});
      mId    = local_id;
      mX     = local_x;
      mY     = local_y;
      mCol   = local_collision;
      mCnt   = 0;
      mFirst = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs the DUT sampled.
   task automatic modelEdge();
      bit ev;
      if (rst) begin
         mQ.delete();
         mDone  = 1'b0;
         mPend  = 1'b0;
         mFirst = 1'b1;
         mCnt   = 0;
         mId    = 2'd0;
         mX     = 8'd0;
         mY     = 8'd0;
         mCol   = 1'b0;
      end else if (mQ.size() > 0) begin
         if (!tx_enable) mPend = 1'b0;
         else if (frame_tick) mPend = 1'b1;
         if (!tx_full) begin
            void'(mQ.pop_front());
            if (mQ.size() == 0) mDone = 1'b1;
         end
      end else begin
         ev = mDone ? ((mPend || frame_tick) && tx_enable) : (frame_tick && tx_enable);
         mDone = 1'b0;
         mPend = 1'b0;
         if (ev) begin
            if (startOk()) launch();
            else if (mCnt < RF - 1) mCnt++;
         end
      end
   endtask

   // Compare the four DUT outputs with the model for the current cycle.
   task automatic checkOutput();
      logic       expWr;
      logic [7:0] expData;
      logic       expBusy;
      logic       expDone;
      expWr   = (mQ.size() > 0) && !tx_full;
      expData = (mQ.size() > 0) ? mQ[0] : 8'h00;
      expBusy = (mQ.size() > 0) || mDone;
      expDone = mDone;
      compared++;
      assert (wr_uart === expWr) else begin
         mismatched++;
         $error("[TB] FAIL wr_uart t=%0t observed=%0b expected=%0b", $time, wr_uart, expWr);
      end
      compared++;
      assert (w_data === expData) else begin
         mismatched++;
         $error("[TB] FAIL w_data t=%0t observed=%02h expected=%02h", $time, w_data, expData);
      end
      compared++;
      assert (busy === expBusy) else begin
         mismatched++;
         $error("[TB] FAIL busy t=%0t observed=%0b expected=%0b", $time, busy, expBusy);
      end
      compared++;
      assert (pkt_done === expDone) else begin
         mismatched++;
         $error("[TB] FAIL pkt_done t=%0t observed=%0b expected=%0b", $time, pkt_done, expDone);
      end
      if (wr_uart === 1'b1) wrLog.push_back(w_data);
   endtask

   // One clock cycle: check outputs mid-cycle, then step the model on the edge.
   task automatic cycle();
      #1;
      checkOutput();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic applyStimulus(input bit tick, input bit en, input bit full);
      frame_tick = tick;
      tx_enable  = en;
      tx_full    = full;
      cycle();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
   endtask

   task automatic expectCount(input string tag, input int exp);
      compared++;
      assert (wrLog.size() === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s byte count observed=%0d expected=%0d", tag, wrLog.size(), exp);
      end
   endtask

   task automatic expectByte(input string tag, input int pos, input logic [7:0] exp);
      logic [7:0] got;
      got = (pos < wrLog.size()) ? wrLog[pos] : 8'hxx;
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s byte%0d observed=%02h expected=%02h", tag, pos, got, exp);
      end
   endtask

   initial begin
      logic [7:0] pktA[6];
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      frame_tick = 1'b0;
      tx_enable  = 1'b1;
      tx_full    = 1'b0;
      local_id   = 2'b01;
      local_x    = 8'hA5;
      local_y    = 8'h3C;
      local_collision = 1'b1;
      pktA = '{8'h10, 8'h51, 8'hA2, 8'h33, 8'hC4, 8'h15};

      // Reset: first edge brings the DUT to a known state, then check it.
      @(posedge clk);
      modelEdge();
      #1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      idleCycles(2);

      // First packet after reset.
      $display("[TB] step: first packet");
      wrLog.delete();
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(9);
      expectCount("first", 6);
      for (int i = 0; i < 6; i++) expectByte("first", i, pktA[i]);

      // Refresh: three unchanged ticks send nothing, the fourth sends.
      $display("[TB] step: refresh");
      wrLog.delete();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         idleCycles(3);
      end
      expectCount("refresh_quiet", 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(9);
      expectCount("refresh_send", 6);

      // Change in x triggers a packet on the next tick.
      $display("[TB] step: change x");
      local_x = 8'hA6;
      wrLog.delete();
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(9);
      expectByte("change", 1, 8'h61);

      // FIFO full stall after the first byte.
      $display("[TB] step: stall");
      local_x = 8'hA5;
      wrLog.delete();
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1);
      idleCycles(9);
      expectCount("stall", 6);
      for (int i = 0; i < 6; i++) expectByte("stall", i, pktA[i]);

      // Input change mid-packet plus a tick while busy.
      $display("[TB] step: mid-packet change");
      local_y = 8'h3D;
      wrLog.delete();
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(3);
      local_x = 8'hFF;
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(12);
      expectCount("midpkt", 12);
      expectByte("midpkt", 1, 8'h51);
      expectByte("midpkt", 2, 8'hA2);
      expectByte("midpkt", 7, 8'hF1);
      expectByte("midpkt", 8, 8'hF2);

      // Link disabled: no packet despite tick and change.
      $display("[TB] step: tx_enable low");
      local_x = 8'h22;
      wrLog.delete();
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      expectCount("disabled", 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(9);
      expectCount("reenabled", 6);

      // Reset during byte 3 aborts; the next tick sends a full packet.
      $display("[TB] step: reset mid-packet");
      local_x = 8'h33;
      wrLog.delete();
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(3);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      idleCycles(5);
      expectCount("abort", 4);
      applyStimulus(1'b1, 1'b1, 1'b0);
      idleCycles(9);
      expectCount("after_reset", 10);
      expectByte("after_reset", 4, 8'h10);

      // Randomized phase, checked cycle by cycle against the model.
      $display("[TB] step: random");
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 7) == 0) local_x = 8'($urandom);
         if ($urandom_range(0, 15) == 0) local_y = 8'($urandom);
         if ($urandom_range(0, 15) == 0) local_collision = 1'($urandom);
         if ($urandom_range(0, 31) == 0) local_id = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         applyStimulus($urandom_range(0, 5) == 0,
                       $urandom_range(0, 9) != 0,
                       $urandom_range(0, 3) == 0);
      end
      rst = 1'b0;
      idleCycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
